// File: rtl/dpsram_sync_pkg.sv
// dpsram_sync_pkg: shared sizing helper for the dual-port RAM slice.
// Optional feature macro used by the slice: DPSRAM_BYPASS_EN.
package dpsram_sync_pkg;

  // Address width is never below one bit, so a depth-1 RAM still has a port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dpsram_sync_lane_mux.sv
// dpsram_sync_lane_mux: per-byte-lane select between a word read from the
// array and a word being written by the other port in the same cycle.
// Ports:
//   i_old  - word as stored before this edge
//   i_new  - write data of the other port
//   i_sel  - one bit per lane, 1 selects i_new for that lane
//   o_data - merged word
module dpsram_sync_lane_mux
  import dpsram_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  localparam int NB        = DATA_WIDTH / BYTE_SIZE
) (
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_new,
  input  logic [NB-1:0]         i_sel,
  output logic [DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_old;
    for (int unsigned k = 0; k < NB; k++) begin
      if (i_sel[k]) o_data[k*BYTE_SIZE +: BYTE_SIZE] = i_new[k*BYTE_SIZE +: BYTE_SIZE];
    end
  end

endmodule

// File: rtl/dpsram_sync.sv
// dpsram_sync: synchronous true dual-port RAM, shared clock, per-byte write
// enables, registered read data on both ports (1-cycle latency, read-first).
// Optional: define DPSRAM_BYPASS_EN to forward the other port's same-cycle
// write data into a colliding read, lane by lane.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   addrX_i, enX_i    - port X word address and enable (gates read and write)
//   weX_i, wdataX_i   - port X byte write enables and write data
//   rdataX_o          - port X registered read data (cleared by rst)
// Out-of-range addresses drop writes and read as zero. Port 1 wins lanes
// that both ports write to the same address in one cycle.
module dpsram_sync
  import dpsram_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int BYTE_SIZE  = 8,
  localparam int ADDR_W    = addr_width(DATA_DEPTH),
  localparam int NB        = DATA_WIDTH / BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr0_i,
  input  logic                  en0_i,
  input  logic [NB-1:0]         we0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  input  logic [ADDR_W-1:0]     addr1_i,
  input  logic                  en1_i,
  input  logic [NB-1:0]         we1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [DATA_WIDTH-1:0] rdata1_o
);

  // Extra MSB keeps the range check meaningful when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

  logic                  w_in0, w_in1;
  logic                  w_wr0, w_wr1;
  logic [DATA_WIDTH-1:0] w_old0, w_old1;
  logic [DATA_WIDTH-1:0] w_rd0, w_rd1;

  assign w_in0  = ({1'b0, addr0_i} < DEPTH_EXT);
  assign w_in1  = ({1'b0, addr1_i} < DEPTH_EXT);
  assign w_wr0  = en0_i & w_in0 & ~rst;
  assign w_wr1  = en1_i & w_in1 & ~rst;
  assign w_old0 = w_in0 ? r_mem[addr0_i] : '0;
  assign w_old1 = w_in1 ? r_mem[addr1_i] : '0;

`ifdef DPSRAM_BYPASS_EN
  logic          w_hit0, w_hit1;
  logic [NB-1:0] w_sel0, w_sel1;

  // Forward only from the other port; a port's own write stays read-first.
  assign w_hit0 = w_wr1 & (addr1_i == addr0_i);
  assign w_hit1 = w_wr0 & (addr0_i == addr1_i);
  assign w_sel0 = we1_i & {NB{w_hit0}};
  assign w_sel1 = we0_i & {NB{w_hit1}};

  dpsram_sync_lane_mux #(.DATA_WIDTH(DATA_WIDTH), .BYTE_SIZE(BYTE_SIZE)) u_mux0 (
    .i_old (w_old0),
    .i_new (wdata1_i),
    .i_sel (w_sel0),
    .o_data(w_rd0)
  );

  dpsram_sync_lane_mux #(.DATA_WIDTH(DATA_WIDTH), .BYTE_SIZE(BYTE_SIZE)) u_mux1 (
    .i_old (w_old1),
    .i_new (wdata0_i),
    .i_sel (w_sel1),
    .o_data(w_rd1)
  );
`else
  assign w_rd0 = w_old0;
  assign w_rd1 = w_old1;
`endif

  // Array has no reset so it maps onto block RAM. Port 1 is applied after
  // port 0 so it takes any lane both ports write.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (w_wr0 && we0_i[k])
        r_mem[addr0_i][k*BYTE_SIZE +: BYTE_SIZE] <= wdata0_i[k*BYTE_SIZE +: BYTE_SIZE];
      if (w_wr1 && we1_i[k])
        r_mem[addr1_i][k*BYTE_SIZE +: BYTE_SIZE] <= wdata1_i[k*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (en0_i) r_rdata0 <= w_rd0;
      if (en1_i) r_rdata1 <= w_rd1;
    end
  end

  assign rdata0_o = r_rdata0;
  assign rdata1_o = r_rdata1;

endmodule

// File: tb/tb_dpsram_sync.sv
module tb_dpsram_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main instance: default 32 x 1024, byte lanes.
  logic [9:0]  addr0, addr1;
  logic        en0, en1;
  logic [3:0]  we0, we1;
  logic [31:0] wdata0, wdata1, rdata0, rdata1;

  // Second instance: non-power-of-two depth, one whole-word lane.
  logic [3:0]  qaddr0, qaddr1;
  logic        qen0, qen1;
  logic [0:0]  qwe0, qwe1;
  logic [15:0] qwdata0, qwdata1, qrdata0, qrdata1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dpsram_sync u_dut (
    .clk(clk), .rst(rst),
    .addr0_i(addr0), .en0_i(en0), .we0_i(we0), .wdata0_i(wdata0), .rdata0_o(rdata0),
    .addr1_i(addr1), .en1_i(en1), .we1_i(we1), .wdata1_i(wdata1), .rdata1_o(rdata1)
  );

  dpsram_sync #(.DATA_WIDTH(16), .DATA_DEPTH(12), .BYTE_SIZE(16)) u_odd (
    .clk(clk), .rst(rst),
    .addr0_i(qaddr0), .en0_i(qen0), .we0_i(qwe0), .wdata0_i(qwdata0), .rdata0_o(qrdata0),
    .addr1_i(qaddr1), .en1_i(qen1), .we1_i(qwe1), .wdata1_i(qwdata1), .rdata1_o(qrdata1)
  );

  typedef struct packed {
    logic        en0;
    logic [3:0]  we0;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic        en1;
    logic [3:0]  we1;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic        c0;
    logic [31:0] x0;
    logic        c1;
    logic [31:0] x1;
  } vec_t;

  vec_t vecs [15];

`ifdef DPSRAM_BYPASS_EN
  localparam logic [31:0] COL7  = 32'h11BB33DD;
  localparam logic [31:0] COL9  = 32'h12345678;
  localparam logic [31:0] DUAL1 = 32'hAAAAAAAA;
`else
  localparam logic [31:0] COL7  = 32'h11223344;
  localparam logic [31:0] COL9  = 32'h00000000;
  localparam logic [31:0] DUAL1 = 32'h55555555;
`endif

  function automatic vec_t mk(
    input logic e0, input logic [3:0] w0, input logic [9:0] a0, input logic [31:0] d0,
    input logic e1, input logic [3:0] w1, input logic [9:0] a1, input logic [31:0] d1,
    input logic c0, input logic [31:0] x0, input logic c1, input logic [31:0] x1);
    vec_t v;
    v = '{e0, w0, a0, d0, e1, w1, a1, d1, c0, x0, c1, x1};
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_main();
    en0 = 1'b0; we0 = '0; addr0 = '0; wdata0 = '0;
    en1 = 1'b0; we1 = '0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic odd_step(input logic e0, input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                          input logic e1, input logic w1, input logic [3:0] a1, input logic [15:0] d1);
    @(negedge clk);
    qen0 = e0; qwe0 = w0; qaddr0 = a0; qwdata0 = d0;
    qen1 = e1; qwe1 = w1; qaddr1 = a1; qwdata1 = d1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0,4'h0,10'd0,32'h0,        1,4'hF,10'd3,32'hDEADBEEF, 1,32'h0,        0,32'h0);
    vecs[1]  = mk(1,4'h0,10'd3,32'h0,        1,4'hF,10'd7,32'h11223344, 1,32'hDEADBEEF, 0,32'h0);
    vecs[2]  = mk(1,4'h0,10'd7,32'h0,        1,4'h5,10'd7,32'hAABBCCDD, 1,COL7,         1,32'h11223344);
    vecs[3]  = mk(1,4'h0,10'd7,32'h0,        0,4'hF,10'd7,32'hFFFFFFFF, 1,32'h11BB33DD, 1,32'h11223344);
    vecs[4]  = mk(1,4'h0,10'd3,32'h0,        0,4'h0,10'd0,32'h0,        1,32'hDEADBEEF, 0,32'h0);
    vecs[5]  = mk(0,4'hF,10'd7,32'hFFFFFFFF, 0,4'h0,10'd0,32'h0,        1,32'hDEADBEEF, 0,32'h0);
    vecs[6]  = mk(1,4'h0,10'd7,32'h0,        0,4'h0,10'd0,32'h0,        1,32'h11BB33DD, 0,32'h0);
    vecs[7]  = mk(1,4'h0,10'd3,32'h0,        1,4'hF,10'd9,32'h0,        1,32'hDEADBEEF, 0,32'h0);
    vecs[8]  = mk(1,4'h0,10'd9,32'h0,        1,4'hF,10'd9,32'h12345678, 1,COL9,         1,32'h0);
    vecs[9]  = mk(1,4'hF,10'd9,32'hCAFEF00D, 0,4'h0,10'd0,32'h0,        1,32'h12345678, 1,32'h0);
    vecs[10] = mk(1,4'hF,10'd2,32'hAAAAAAAA, 1,4'hF,10'd2,32'h55555555, 0,32'h0,        0,32'h0);
    vecs[11] = mk(1,4'h0,10'd2,32'h0,        1,4'h0,10'd9,32'h0,        1,32'h55555555, 1,32'hCAFEF00D);
    vecs[12] = mk(1,4'hF,10'd2,32'hAAAAAAAA, 1,4'h1,10'd2,32'h55555555, 1,32'h55555555, 1,DUAL1);
    vecs[13] = mk(1,4'h0,10'd2,32'h0,        1,4'h0,10'd3,32'h0,        1,32'hAAAAAA55, 1,32'hDEADBEEF);
    vecs[14] = mk(0,4'h0,10'd0,32'h0,        1,4'hF,10'd5,32'h0BADC0DE, 0,32'h0,        0,32'h0);

    idle_main();
    qen0 = 1'b0; qwe0 = '0; qaddr0 = '0; qwdata0 = '0;
    qen1 = 1'b0; qwe1 = '0; qaddr1 = '0; qwdata1 = '0;

    // Reset state, with enables high so a missing reset would show memory.
    en0 = 1'b1; en1 = 1'b1;
    @(posedge clk);
    #1;
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_rdata1", rdata1, 32'h0);
    @(negedge clk);
    idle_main();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      en0 = vecs[i].en0; we0 = vecs[i].we0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      en1 = vecs[i].en1; we1 = vecs[i].we1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(posedge clk);
      #1;
      if (vecs[i].c0) check($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].x0);
      if (vecs[i].c1) check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].x1);
    end

    // Mid-cycle asynchronous reset, write attempted under reset, contents kept.
    @(negedge clk);
    idle_main();
    en0 = 1'b1; addr0 = 10'd5;
    en1 = 1'b1; addr1 = 10'd3;
    @(posedge clk);
    #1;
    check("pre_rst_rdata0", rdata0, 32'h0BADC0DE);
    check("pre_rst_rdata1", rdata1, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rdata0", rdata0, 32'h0);
    check("async_rst_rdata1", rdata1, 32'h0);
    we1 = 4'hF; addr1 = 10'd5; wdata1 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    check("in_rst_rdata0", rdata0, 32'h0);
    check("in_rst_rdata1", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we1 = '0; addr1 = 10'd5; wdata1 = '0;
    @(posedge clk);
    #1;
    check("post_rst_rdata0", rdata0, 32'h0BADC0DE);
    check("post_rst_rdata1", rdata1, 32'h0BADC0DE);
    @(negedge clk);
    idle_main();

    // Non-power-of-two depth: writes past the end are dropped, reads give 0.
    odd_step(1, 1'b1, 4'd1,  16'h0001, 1, 1'b1, 4'd11, 16'h1234);
    odd_step(1, 1'b1, 4'd13, 16'hBEEF, 1, 1'b1, 4'd12, 16'h5555);
    odd_step(1, 1'b0, 4'd13, 16'h0,    1, 1'b0, 4'd11, 16'h0);
    check("odd_oor_read13", {16'h0, qrdata0}, 32'h0);
    check("odd_last_word", {16'h0, qrdata1}, 32'h1234);
    odd_step(1, 1'b0, 4'd1,  16'h0,    1, 1'b0, 4'd12, 16'h0);
    check("odd_no_alias1", {16'h0, qrdata0}, 32'h0001);
    check("odd_oor_read12", {16'h0, qrdata1}, 32'h0);
    odd_step(1, 1'b0, 4'd11, 16'h0,    0, 1'b0, 4'd1,  16'h0);
    check("odd_word11", {16'h0, qrdata0}, 32'h1234);
    check("odd_hold1", {16'h0, qrdata1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpsram_sync.md
Name: dpsram_sync

Overview:
- Synchronous true dual-port RAM with per-byte write enables and registered read outputs on both ports.
- Both ports share one clock.
- Used as the BTB storage in the branch predictor: port 0 is the read-only lookup port, port 1 is the update/write port. It is also a generic RAM primitive elsewhere.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_SIZE.
- DATA_DEPTH, 1024, number of words; ADDR_W = max(1, $clog2(DATA_DEPTH)).
- BYTE_SIZE, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_SIZE. Setting BYTE_SIZE = DATA_WIDTH gives a single whole-word enable.

Ports:
- clk  in  1  single clock for both ports; rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr0_i  in  ADDR_W  port-0 word address.
- en0_i  in  1  port-0 enable; gates both read and write.
- we0_i  in  NB  port-0 byte write enables; lane k covers bits [k*BYTE_SIZE +: BYTE_SIZE].
- wdata0_i  in  DATA_WIDTH  port-0 write data.
- rdata0_o  out  DATA_WIDTH  port-0 registered read data.
- addr1_i  in  ADDR_W  port-1 word address.
- en1_i  in  1  port-1 enable.
- we1_i  in  NB  port-1 byte write enables.
- wdata1_i  in  DATA_WIDTH  port-1 write data.
- rdata1_o  out  DATA_WIDTH  port-1 registered read data.

Behaviour:
- Reset:
  - rst asserted clears rdata0_o and rdata1_o to 0 immediately, without waiting for a clock edge.
  - Memory array is not reset; contents are unchanged by rst and undefined at power-up.
  - No reads or writes occur while rst is high.
- Read:
  - On a rising clk edge with enX_i = 1, rdataX_o <= mem[addrX_i]. Latency is exactly 1 cycle.
  - With enX_i = 0, rdataX_o holds its previous value.
- Write:
  - On a rising clk edge with enX_i = 1, each lane k with weX_i[k] = 1 takes mem[addrX_i] lane k <= wdataX_i lane k.
  - Lanes with weX_i[k] = 0 are unchanged.
  - weX_i is ignored when enX_i = 0.
- Same-port read-during-write: read-first. rdataX_o returns the word as it was before the edge's write, in all lanes.
- Cross-port collision (one port reads address A while the other writes A in the same cycle): reader gets the old data, unless DPSRAM_BYPASS_EN is defined.
- Both ports write the same address in the same cycle: per lane, port 1 wins wherever both enables are set; lanes written by only one port take that port's data.
- Out-of-range address (addr >= DATA_DEPTH, possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns 0.
- No handshake, no stall; every enabled cycle is accepted.
- Must infer block RAM: the memory array has no reset, and the registered outputs are the only reset flops.

Optional Feature:
- DPSRAM_BYPASS_EN defined:
  - Cross-port write-to-read forwarding. When port Y writes address A in the same enabled cycle that port X reads A, rdataX_o shows port Y's new data in lanes where weY_i[k] = 1, and old data in the other lanes.
  - Same-port behaviour stays read-first.
  - Adds one address comparator and an NB-lane mux per port.
- DPSRAM_BYPASS_EN undefined: pure read-first collision behaviour as in Behaviour.

Decomposition:
- No shared package types needed.
- ADDR_W and NB are computed locally as localparams.
- One natural sub-module: dpsram_lane_mux, the per-lane select of old vs forwarded data, instantiated twice only under DPSRAM_BYPASS_EN.
- Callers pack structs to DATA_WIDTH with $bits and set BYTE_SIZE = DATA_WIDTH.

Test Plan:
- Reset: drive port-0 read of a written word, then assert rst mid-cycle -> rdata0_o and rdata1_o become 0 before the next edge; after release, a read of addr 5 returns pre-reset contents.
- Basic: port1 writes 0xDEADBEEF @ addr 3 (we = 4'hF); next cycle port0 reads addr 3 -> rdata0_o = 0xDEADBEEF exactly one cycle after the address is presented.
- Byte lanes: mem[7] = 0x11223344; port1 writes 0xAABBCCDD with we = 4'b0101 -> subsequent read gives 0x11BB33DD.
- Enable hold: port0 reads 0xDEADBEEF, then en0_i = 0 with addr changed -> rdata0_o stays 0xDEADBEEF; a write with en1_i = 0 and we1_i = 4'hF leaves memory unchanged.
- Collision:
  - mem[9] = 0x0; port1 writes 0x12345678 @9 while port0 reads 9 -> rdata0_o = 0x0 without the macro, 0x12345678 with DPSRAM_BYPASS_EN.
  - Same-port write+read of 9 -> old value in both builds.
- Dual write: both ports write addr 2 with we = 4'hF, data 0xAAAAAAAA (p0) and 0x55555555 (p1) -> mem[2] = 0x55555555; repeat with we0 = 4'hF, we1 = 4'h1 -> 0xAAAAAA55.
